// File: rtl/aes_pkg.sv
// Shared AES definitions: Rcon seed, reduction polynomial, round count, key-schedule states, xtime.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package aes_pkg;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] AES_POLY   = 8'h1b;
  localparam int         AES_NR     = 10;
  localparam logic [3:0] LAST_ROUND = 4'(AES_NR);

  typedef logic [127:0] rkey_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Key-load handshake, status and round-key read port of the key-schedule engine.
// Latency: n/a (wires only).
// Backpressure: key_ready low while an expansion is running; upstream holds key.
interface aes_key_expand_seq_if;
  import aes_pkg::*;

  rkey_t      key;
  logic       key_valid;
  logic       key_ready;
  logic       busy;
  logic       done;
  logic       keys_valid;
  logic [3:0] rk_idx;
  rkey_t      rk;

  modport master (
    output key, key_valid, rk_idx,
    input  key_ready, busy, done, keys_valid, rk
  );

  modport slave (
    input  key, key_valid, rk_idx,
    output key_ready, busy, done, keys_valid, rk
  );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in, one byte out.
// Latency: purely combinational.
// Backpressure: none.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry 0 sits in the top byte, so entry n starts at bit 8*(255-n) = {~n, 3'b000}.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX_TBL[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: accepts a key, produces rk0..rk10 one per clock into a register file.
// Latency: rk10 written 10 cycles after the accept edge; read port returns rk[rk_idx] one cycle after sampling.
// Backpressure: key_ready low during expansion; a key offered then is ignored until the engine is idle.
module aes_key_expand_seq
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  aes_key_expand_seq_if.slave   kif
);

  ks_state_t  state_q, state_d;
  logic       accept;
  logic       last_round;

  logic [3:0] cnt_q;
  logic [7:0] rcon_q;
  rkey_t      work_q;
  rkey_t      rf [0:AES_NR];
  rkey_t      rk_q;
  logic       done_q;
  logic       keys_valid_q;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3, t;
  logic [31:0] n0, n1, n2, n3;
  rkey_t       next_rk;

  // Round function: one S-box level followed by the 4-word XOR chain.
  assign {w0, w1, w2, w3} = work_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_w3[8*g +: 8]),
      .dout (sub_w3[8*g +: 8])
    );
  end

  assign t       = sub_w3 ^ {rcon_q, 24'h000000};
  assign n0      = w0 ^ t;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // Next-state logic: accept only in IDLE, leave EXPAND on the round that writes rk10.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    last_round = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (kif.key_valid) begin
          accept  = 1'b1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (cnt_q == LAST_ROUND) begin
          last_round = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Working words, Rcon, round counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 4'd0;
      rcon_q       <= RCON_INIT;
      work_q       <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      done_q <= last_round;
      if (accept) begin
        work_q       <= kif.key;
        rcon_q       <= RCON_INIT;
        cnt_q        <= 4'd1;
        keys_valid_q <= 1'b0;
      end else if (state_q == ST_EXPAND) begin
        work_q <= next_rk;
        rcon_q <= xtime(rcon_q);
        cnt_q  <= cnt_q + 4'd1;
        if (last_round) begin
          keys_valid_q <= 1'b1;
        end
      end
    end
  end

  // Round-key storage; contents survive reset, only the valid flag says whether they are usable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        rf[0] <= kif.key;
      end else if (state_q == ST_EXPAND) begin
        rf[cnt_q] <= next_rk;
      end
    end
  end

  // Registered read port; a same-edge write is not forwarded, so the old entry is returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_q <= '0;
    end else if (kif.rk_idx <= LAST_ROUND) begin
      rk_q <= rf[kif.rk_idx];
    end else begin
      rk_q <= '0;
    end
  end

  assign kif.key_ready  = (state_q == ST_IDLE);
  assign kif.busy       = (state_q == ST_EXPAND);
  assign kif.done       = done_q;
  assign kif.keys_valid = keys_valid_q;
  assign kif.rk         = rk_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: FIPS-197 vectors, random keys against a word-level key-schedule model,
// busy rejection, mid-expansion reset, out-of-range reads and an end-to-end cipher on the read-back keys.
module tb_aes_key_expand_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_expand_seq_if kif ();

  aes_key_expand_seq dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]   sb  [0:255];
  logic [127:0] mrk [0:10];
  logic [127:0] drk [0:10];

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] x;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      if (x != 8'h00) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, x);
      end
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  // Textbook 44-word expansion into mrk[0..10].
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Full AES-128 encryption using round keys in drk[].
  function automatic logic [127:0] cipher(input logic [127:0] pt);
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] blk;
    blk = pt ^ drk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[blk[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
      blk = blk ^ drk[r];
    end
    return blk;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (kif.done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("done_seen", 128'(kif.done), 128'd1);
  endtask

  // Offer a key, wait for the accept edge, then wait for done; lat = cycles from accept to done.
  task automatic send_key(input logic [127:0] k, output int lat);
    int w;
    kif.key       = k;
    kif.key_valid = 1'b1;
    w = 0;
    while (kif.key_ready !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    check("ready_before_accept", 128'(kif.key_ready), 128'd1);
    step();
    kif.key_valid = 1'b0;
    check("busy_after_accept", 128'(kif.busy), 128'd1);
    check("ready_low_after_accept", 128'(kif.key_ready), 128'd0);
    check("kv_clear_after_accept", 128'(kif.keys_valid), 128'd0);
    wait_done(lat);
    check("latency", 128'(lat), 128'd10);
    check("kv_after_done", 128'(kif.keys_valid), 128'd1);
  endtask

  task automatic read_chk(input string tag, input int idx, input logic [127:0] exp);
    kif.rk_idx = 4'(idx);
    step();
    check(tag, kif.rk, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           lat;
    int           n;
    logic [127:0] ka, kb, a_rk10;

    build_sbox();
    rst           = 1'b1;
    kif.key       = '0;
    kif.key_valid = 1'b0;
    kif.rk_idx    = 4'd0;
    step();
    step();

    // Reset state.
    check("rst_busy",  128'(kif.busy),       128'd0);
    check("rst_done",  128'(kif.done),       128'd0);
    check("rst_kv",    128'(kif.keys_valid), 128'd0);
    check("rst_ready", 128'(kif.key_ready),  128'd1);
    check("rst_rk",    kif.rk,               128'd0);
    rst = 1'b0;
    step();

    // FIPS-197 C.1 key, directed and model, then end-to-end encryption.
    send_key(C1_KEY, lat);
    read_chk("c1_rk0",  0,  C1_KEY);
    read_chk("c1_rk1",  1,  C1_RK1);
    read_chk("c1_rk10", 10, C1_RK10);
    model_expand(C1_KEY);
    for (int i = 0; i < 11; i++) begin
      read_chk("c1_rk_model", i, mrk[i]);
      drk[i] = kif.rk;
    end
    check("c1_cipher", cipher(C1_PT), C1_CT);

    // FIPS-197 A.1 key (re-key while keys_valid is set).
    check("kv_before_rekey", 128'(kif.keys_valid), 128'd1);
    send_key(A1_KEY, lat);
    read_chk("a1_rk1",  1,  A1_RK1);
    read_chk("a1_rk10", 10, A1_RK10);

    // Random keys against the model.
    for (int j = 0; j < 4; j++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      model_expand(ka);
      send_key(ka, lat);
      for (int i = 0; i < 11; i++) read_chk("rand_rk", i, mrk[i]);
    end

    // Second key offered while busy is held off until the first expansion completes.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    model_expand(ka);
    a_rk10 = mrk[10];
    kif.key       = ka;
    kif.key_valid = 1'b1;
    step();
    kif.key_valid = 1'b0;
    step(); step(); step();
    kif.key       = kb;
    kif.key_valid = 1'b1;
    n = 3;
    while (kif.done !== 1'b1 && n < 40) begin
      check("ready_low_busy", 128'(kif.key_ready), 128'd0);
      step();
      n++;
    end
    check("busy_rej_done_cycle", 128'(n), 128'd10);
    check("busy_rej_ready_at_done", 128'(kif.key_ready), 128'd1);
    kif.rk_idx = 4'd10;
    step();
    kif.key_valid = 1'b0;
    check("busy_rej_first_rk10", kif.rk, a_rk10);
    check("busy_rej_second_accepted", 128'(kif.busy), 128'd1);
    model_expand(kb);
    wait_done(lat);
    check("busy_rej_second_latency", 128'(lat), 128'd10);
    read_chk("busy_rej_second_rk10", 10, mrk[10]);

    // Reset in cycle 5 of an expansion.
    kif.key       = C1_KEY;
    kif.key_valid = 1'b1;
    step();
    kif.key_valid = 1'b0;
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    check("midrst_busy",  128'(kif.busy),       128'd0);
    check("midrst_kv",    128'(kif.keys_valid), 128'd0);
    check("midrst_rk",    kif.rk,               128'd0);
    check("midrst_ready", 128'(kif.key_ready),  128'd1);
    check("midrst_done",  128'(kif.done),       128'd0);
    rst = 1'b0;
    send_key(C1_KEY, lat);
    read_chk("midrst_rk10", 10, C1_RK10);

    // Out-of-range indices read as zero.
    read_chk("oor_11", 11, 128'd0);
    read_chk("oor_15", 15, 128'd0);
    read_chk("oor_back_10", 10, C1_RK10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
